// File: rtl/nvdla_glb_done_intr_gen_if.sv
// Bundle between the layer-done sources and the done-interrupt generator.
//   master: op_done, wr_req_accept, wr_rsp_done, err_clr (driven);
//           done_intr_pd, outstanding_cnt, pend_cnt, err_sticky (observed)
//   slave : the mirror view, used by nvdla_glb_done_intr_gen
interface nvdla_glb_done_intr_gen_if #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [1:0]              op_done;
  logic                    wr_req_accept;
  logic                    wr_rsp_done;
  logic                    err_clr;
  logic [1:0]              done_intr_pd;
  logic [CNT_W-1:0]        outstanding_cnt;
  logic [$clog2(QDEPTH):0] pend_cnt;
  logic [1:0]              err_sticky;

  modport master (
    output op_done, wr_req_accept, wr_rsp_done, err_clr,
    input  done_intr_pd, outstanding_cnt, pend_cnt, err_sticky
  );

  modport slave (
    input  op_done, wr_req_accept, wr_rsp_done, err_clr,
    output done_intr_pd, outstanding_cnt, pend_cnt, err_sticky
  );
endinterface

// File: rtl/nvdla_glb_done_intr_gen.sv
// Layer-done interrupt generator: queues per-group done events and emits one
// single-cycle one-hot pulse per event, in arrival order, at most one every
// two cycles. With GLB_INTR_WR_DRAIN_EN defined, a pulse is held back until
// every accepted DMA write has been responded to (outstanding counter at 0).
// Ports:
//   nvdla_core_clk  : clock, rising edge
//   nvdla_core_rstn : asynchronous active-low reset
//   glb (slave)     : op_done / wr_req_accept / wr_rsp_done / err_clr in,
//                     done_intr_pd / outstanding_cnt / pend_cnt / err_sticky out
module nvdla_glb_done_intr_gen #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input logic                      nvdla_core_clk,
  input logic                      nvdla_core_rstn,
  nvdla_glb_done_intr_gen_if.slave glb
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef GLB_INTR_WR_DRAIN_EN
    S_WAIT = 2'd1,
`endif
    S_FIRE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [QDEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     pend_q, pend_d;
  logic [1:0]        pd_q, pd_d;
  logic [1:0]        err_q, err_d;

  logic              pop_c, push0_c, push1_c, q_ovf_c;
  logic [PW-1:0]     free_c;
  logic [AW-1:0]     wr_ptr1_c;
  logic              drain_ok_c;
  logic              cnt_err_c;

  // Outstanding-write counter; saturates at both ends and flags the attempt.
`ifdef GLB_INTR_WR_DRAIN_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    cnt_err_c = 1'b0;
    if (glb.wr_req_accept && !glb.wr_rsp_done) begin
      if (&cnt_q) cnt_err_c = 1'b1;
      else        cnt_d     = cnt_q + CNT_W'(1);
    end else if (glb.wr_rsp_done && !glb.wr_req_accept) begin
      if (cnt_q == '0) cnt_err_c = 1'b1;
      else             cnt_d     = cnt_q - CNT_W'(1);
    end
  end

  assign drain_ok_c          = (cnt_q == '0);
  assign glb.outstanding_cnt = cnt_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end
`else
  logic unused_wr_c;

  assign unused_wr_c         = glb.wr_req_accept ^ glb.wr_rsp_done;
  assign cnt_err_c           = 1'b0;
  assign drain_ok_c          = 1'b1;
  assign glb.outstanding_cnt = '0;
`endif

  // Pending-done FIFO. A pop in FIRE frees its slot for this cycle's pushes;
  // group 0 takes the first free slot when both groups finish together.
  always_comb begin
    pop_c     = (state_q == S_FIRE);
    free_c    = PW'(QDEPTH) - pend_q + PW'(pop_c);
    push0_c   = glb.op_done[0] && (free_c != '0);
    push1_c   = glb.op_done[1] && (free_c > PW'(push0_c));
    q_ovf_c   = (glb.op_done[0] && !push0_c) || (glb.op_done[1] && !push1_c);
    wr_ptr1_c = wr_ptr_q + AW'(push0_c);
    mem_d     = mem_q;
    if (push0_c) mem_d[wr_ptr_q]  = 1'b0;
    if (push1_c) mem_d[wr_ptr1_c] = 1'b1;
    wr_ptr_d  = wr_ptr1_c + AW'(push1_c);
    rd_ptr_d  = rd_ptr_q + AW'(pop_c);
    pend_d    = pend_q - PW'(pop_c) + PW'(push0_c) + PW'(push1_c);
  end

  // Sticky errors; a new event in the clearing cycle keeps its bit set.
  always_comb begin
    err_d    = err_q & {2{~glb.err_clr}};
    err_d[0] = err_d[0] | q_ovf_c;
`ifdef GLB_INTR_WR_DRAIN_EN
    err_d[1] = err_d[1] | cnt_err_c;
`else
    err_d[1] = 1'b0;
`endif
  end

  // Next state and registered pulse; the head only leaves while in FIRE.
  always_comb begin
    state_d = state_q;
    pd_d    = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
`ifdef GLB_INTR_WR_DRAIN_EN
          state_d = drain_ok_c ? S_FIRE : S_WAIT;
`else
          state_d = S_FIRE;
`endif
        end
      end
`ifdef GLB_INTR_WR_DRAIN_EN
      S_WAIT: begin
        if (drain_ok_c) state_d = S_FIRE;
      end
`endif
      S_FIRE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FIRE) pd_d = mem_q[rd_ptr_q] ? 2'b10 : 2'b01;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= S_IDLE;
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pend_q   <= '0;
      pd_q     <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pend_q   <= pend_d;
      pd_q     <= pd_d;
      err_q    <= err_d;
    end
  end

  assign glb.done_intr_pd = pd_q;
  assign glb.pend_cnt     = pend_q;
  assign glb.err_sticky   = err_q;

endmodule

// File: tb/tb_nvdla_glb_done_intr_gen.sv
// Self-checking bench for nvdla_glb_done_intr_gen. Builds with or without
// GLB_INTR_WR_DRAIN_EN; expectations follow the selected configuration.
module tb_nvdla_glb_done_intr_gen;

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PW     = $clog2(QDEPTH) + 1;
`ifdef GLB_INTR_WR_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  nvdla_glb_done_intr_gen_if #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) bus ();

  nvdla_glb_done_intr_gen #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .glb            (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of group IDs, write count, sticky errors, pulse.
  bit         m_q[$];
  int         m_cnt;
  logic [1:0] m_err;
  logic [1:0] m_pd;

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0;
    m_err = 2'b00;
    m_pd  = 2'b00;
  endtask

  // A pulse goes out when none went out last cycle, something was queued,
  // and (with drain) no write was outstanding; the pulsed head leaves next.
  task automatic model_edge(input logic [1:0] op, input logic req,
                            input logic rsp, input logic clr);
    logic [1:0] npd;
    logic       ovq;
    logic       ovc;
    npd = 2'b00;
    ovq = 1'b0;
    ovc = 1'b0;
    if (m_pd == 2'b00 && m_q.size() > 0 && (!DRAIN || m_cnt == 0))
      npd = m_q[0] ? 2'b10 : 2'b01;
    if (m_pd != 2'b00) void'(m_q.pop_front());
    for (int g = 0; g < 2; g++) begin
      if (op[g]) begin
        if (m_q.size() < QDEPTH) m_q.push_back(g == 1);
        else ovq = 1'b1;
      end
    end
    if (DRAIN) begin
      if (req && !rsp) begin
        if (m_cnt == (1 << CNT_W) - 1) ovc = 1'b1;
        else m_cnt++;
      end else if (rsp && !req) begin
        if (m_cnt == 0) ovc = 1'b1;
        else m_cnt--;
      end
    end
    m_err[0] = ovq | (m_err[0] & ~clr);
    m_err[1] = ovc | (m_err[1] & ~clr);
    m_pd = npd;
  endtask

  task automatic tick(input logic [1:0] op, input logic req,
                      input logic rsp, input logic clr);
    bus.op_done       = op;
    bus.wr_req_accept = req;
    bus.wr_rsp_done   = rsp;
    bus.err_clr       = clr;
    @(posedge clk);
    model_edge(op, req, rsp, clr);
    #1;
  endtask

  task automatic drive_idle();
    bus.op_done       = 2'b00;
    bus.wr_req_accept = 1'b0;
    bus.wr_rsp_done   = 1'b0;
    bus.err_clr       = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.done_intr_pd !== 2'b00) begin bad++; $display("FAIL reset_pd: got %b want 00", bus.done_intr_pd); end
    total++; if (bus.pend_cnt !== '0) begin bad++; $display("FAIL reset_pend: got %0d want 0", bus.pend_cnt); end
    total++; if (bus.outstanding_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.outstanding_cnt); end
    total++; if (bus.err_sticky !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", bus.err_sticky); end
    @(negedge clk);
    rstn = 1'b1;
    // first edge after release must already act
    tick(2'b01, 1'b1, 1'b0, 1'b0);
    total++; if (bus.pend_cnt !== PW'(m_q.size())) begin bad++; $display("FAIL first_edge_pend: got %0d want %0d", bus.pend_cnt, m_q.size()); end
    total++; if (bus.outstanding_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL first_edge_cnt: got %0d want %0d", bus.outstanding_cnt, m_cnt); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.done_intr_pd !== m_pd) begin bad++; $display("FAIL first_edge_pd: got %b want %b", bus.done_intr_pd, m_pd); end
    // asynchronous assertion, checked before any clock edge
    #2 rstn = 1'b0;
    model_reset();
    #1;
    total++; if ({bus.done_intr_pd, bus.err_sticky} !== 4'b0000) begin bad++; $display("FAIL async_reset_pd_err: got %b want 0000", {bus.done_intr_pd, bus.err_sticky}); end
    total++; if (bus.pend_cnt !== '0 || bus.outstanding_cnt !== '0) begin bad++; $display("FAIL async_reset_cnts: got pend=%0d cnt=%0d want 0/0", bus.pend_cnt, bus.outstanding_cnt); end
    drive_idle();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_latency();
    do_reset();
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    total++; if (bus.done_intr_pd !== 2'b00) begin bad++; $display("FAIL latency_n1: got %b want 00", bus.done_intr_pd); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.done_intr_pd !== 2'b01) begin bad++; $display("FAIL latency_n2: got %b want 01", bus.done_intr_pd); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.done_intr_pd !== 2'b00) begin bad++; $display("FAIL latency_n3: got %b want 00", bus.done_intr_pd); end
  endtask

  // Three writes, done of group 1 at cycle 10, responses at 20/25/30.
  task automatic test_drain();
    int ec;
    int pulse_at;
    logic [1:0] op;
    logic req, rsp;
    do_reset();
    ec = 0;
    pulse_at = DRAIN ? 32 : 12;
    for (int c = 7; c <= 34; c++) begin
      op  = (c == 10) ? 2'b10 : 2'b00;
      req = (c <= 9);
      rsp = (c == 20 || c == 25 || c == 30);
      tick(op, req, rsp, 1'b0);
      if (DRAIN) ec = ec + int'(req) - int'(rsp);
      total++; if (bus.done_intr_pd !== ((c + 1 == pulse_at) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL drain_pd cyc %0d: got %b want %b", c + 1, bus.done_intr_pd, (c + 1 == pulse_at) ? 2'b10 : 2'b00); end
      total++; if (bus.outstanding_cnt !== CNT_W'(ec)) begin bad++; $display("FAIL drain_cnt cyc %0d: got %0d want %0d", c + 1, bus.outstanding_cnt, ec); end
    end
    total++; if (bus.err_sticky !== 2'b00) begin bad++; $display("FAIL drain_err: got %b want 00", bus.err_sticky); end
  endtask

  task automatic test_dual();
    logic [1:0] exp_pd[5];
    int         exp_pend[5];
    exp_pd   = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    exp_pend = '{2, 2, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick((k == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0);
      total++; if (bus.done_intr_pd !== exp_pd[k]) begin bad++; $display("FAIL dual_pd step %0d: got %b want %b", k, bus.done_intr_pd, exp_pd[k]); end
      total++; if (bus.pend_cnt !== PW'(exp_pend[k])) begin bad++; $display("FAIL dual_pend step %0d: got %0d want %0d", k, bus.pend_cnt, exp_pend[k]); end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] seen[$];
    logic [1:0] want[4];
    do_reset();
`ifdef GLB_INTR_WR_DRAIN_EN
    repeat (5) tick(2'b00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pend_cnt !== PW'(4)) begin bad++; $display("FAIL ovf_pend: got %0d want 4", bus.pend_cnt); end
    total++; if (bus.err_sticky !== 2'b01) begin bad++; $display("FAIL ovf_err: got %b want 01", bus.err_sticky); end
    repeat (5) tick(2'b00, 1'b0, 1'b1, 1'b0);
    want = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    // full queue with a same-cycle pop: one slot frees, group 0 kept
    repeat (3) tick(2'b11, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pend_cnt !== PW'(4)) begin bad++; $display("FAIL ovf_pend: got %0d want 4", bus.pend_cnt); end
    total++; if (bus.err_sticky !== 2'b01) begin bad++; $display("FAIL ovf_err: got %b want 01", bus.err_sticky); end
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    total++; if (bus.err_sticky !== 2'b00) begin bad++; $display("FAIL ovf_clr: got %b want 00", bus.err_sticky); end
    if (bus.done_intr_pd != 2'b00) seen.push_back(bus.done_intr_pd);
    repeat (12) begin
      tick(2'b00, 1'b0, 1'b0, 1'b0);
      if (bus.done_intr_pd != 2'b00) seen.push_back(bus.done_intr_pd);
    end
    total++; if (seen.size() != 4) begin bad++; $display("FAIL ovf_pulse_count: got %0d want 4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      total++; if (seen[k] !== want[k]) begin bad++; $display("FAIL ovf_order %0d: got %b want %b", k, seen[k], want[k]); end
    end
  endtask

  task automatic test_counter_err();
    do_reset();
`ifdef GLB_INTR_WR_DRAIN_EN
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    total++; if (bus.outstanding_cnt !== '0 || bus.err_sticky !== 2'b10) begin bad++; $display("FAIL underflow: got cnt=%0d err=%b want 0/10", bus.outstanding_cnt, bus.err_sticky); end
    tick(2'b00, 1'b0, 1'b1, 1'b1);
    total++; if (bus.err_sticky !== 2'b10) begin bad++; $display("FAIL set_beats_clr: got %b want 10", bus.err_sticky); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    total++; if (bus.err_sticky !== 2'b00) begin bad++; $display("FAIL cnt_clr: got %b want 00", bus.err_sticky); end
    repeat (2) tick(2'b00, 1'b1, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b1, 1'b0);
    total++; if (bus.outstanding_cnt !== CNT_W'(2)) begin bad++; $display("FAIL req_rsp_hold: got %0d want 2", bus.outstanding_cnt); end
    repeat (253) tick(2'b00, 1'b1, 1'b0, 1'b0);
    total++; if (bus.outstanding_cnt !== CNT_W'(255) || bus.err_sticky !== 2'b00) begin bad++; $display("FAIL cnt_max: got cnt=%0d err=%b want 255/00", bus.outstanding_cnt, bus.err_sticky); end
    tick(2'b00, 1'b1, 1'b0, 1'b0);
    total++; if (bus.outstanding_cnt !== CNT_W'(255) || bus.err_sticky !== 2'b10) begin bad++; $display("FAIL overflow: got cnt=%0d err=%b want 255/10", bus.outstanding_cnt, bus.err_sticky); end
`else
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(2'b00, 1'b1, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b1, 1'b0);
    total++; if (bus.outstanding_cnt !== '0 || bus.err_sticky !== 2'b00) begin bad++; $display("FAIL cnt_ignored: got cnt=%0d err=%b want 0/00", bus.outstanding_cnt, bus.err_sticky); end
`endif
  endtask

  task automatic test_reset_midwait();
    do_reset();
    tick(2'b00, 1'b1, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.done_intr_pd !== m_pd || bus.pend_cnt !== PW'(m_q.size())) begin bad++; $display("FAIL midwait_pre: got pd=%b pend=%0d want %b/%0d", bus.done_intr_pd, bus.pend_cnt, m_pd, m_q.size()); end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    total++; if ({bus.done_intr_pd, bus.err_sticky, bus.pend_cnt, bus.outstanding_cnt} !== '0) begin bad++; $display("FAIL midwait_reset: got pd=%b err=%b pend=%0d cnt=%0d want all 0", bus.done_intr_pd, bus.err_sticky, bus.pend_cnt, bus.outstanding_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(2'b00, 1'b0, 1'b0, 1'b0);
      total++; if (bus.done_intr_pd !== 2'b00 || bus.pend_cnt !== '0) begin bad++; $display("FAIL midwait_after %0d: got pd=%b pend=%0d want 00/0", k, bus.done_intr_pd, bus.pend_cnt); end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic req, rsp, clr;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      op  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      req = ($urandom_range(0, 2) == 0);
      rsp = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      tick(op, req, rsp, clr);
      total++; if (bus.done_intr_pd !== m_pd) begin bad++; $display("FAIL rand_pd cyc %0d: got %b want %b", i, bus.done_intr_pd, m_pd); end
      total++; if (bus.pend_cnt !== PW'(m_q.size())) begin bad++; $display("FAIL rand_pend cyc %0d: got %0d want %0d", i, bus.pend_cnt, m_q.size()); end
      total++; if (bus.outstanding_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rand_cnt cyc %0d: got %0d want %0d", i, bus.outstanding_cnt, m_cnt); end
      total++; if (bus.err_sticky !== m_err) begin bad++; $display("FAIL rand_err cyc %0d: got %b want %b", i, bus.err_sticky, m_err); end
      total++; if (bus.done_intr_pd === 2'b11) begin bad++; $display("FAIL rand_both_hot cyc %0d: got 11 want not 11", i); end
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_latency();
    test_drain();
    test_dual();
    test_overflow();
    test_counter_err();
    test_reset_midwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvdla_glb_done_intr_gen.md
NVDLA_GLB_DONE_INTR_GEN -- requirements
Module: nvdla_glb_done_intr_gen

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: pending-done queue depth in entries; power of 2, at least 2.
REQ-002 SHALL have parameter CNT_W, default 8: outstanding-write counter width.
REQ-003 SHALL have port nvdla_core_clk, input, 1 bit: the single clock; all state samples on its rising edge.
REQ-004 SHALL have port nvdla_core_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op_done, input, 2 bits: bit g high for one cycle means the layer in register group g has finished computing.
REQ-006 SHALL have port wr_req_accept, input, 1 bit: one DMA write request was accepted this cycle.
REQ-007 SHALL have port wr_rsp_done, input, 1 bit: one DMA write response was returned this cycle.
REQ-008 SHALL have port err_clr, input, 1 bit: clears err_sticky.
REQ-009 SHALL have port done_intr_pd, output, 2 bits: one-hot, single-cycle done pulse per group, feeding the global interrupt controller.
REQ-010 SHALL have port outstanding_cnt, output, CNT_W bits: current count of writes not yet responded.
REQ-011 SHALL have port pend_cnt, output, log2(QDEPTH)+1 bits: number of occupied queue entries.
REQ-012 SHALL have port err_sticky, output, 2 bits: bit0 = queue overflow; bit1 = counter overflow or underflow.

Function
REQ-013 Counter: SHALL increment by 1 on wr_req_accept alone, decrement by 1 on wr_rsp_done alone, and hold when both or neither assert.
REQ-014 Counter underflow (decrement at 0) SHALL hold 0 and set err_sticky[1].
REQ-015 Counter overflow (increment at all-ones) SHALL hold all-ones and set err_sticky[1].
REQ-016 Queue: FIFO of 1-bit group IDs.
REQ-017 Queue push: a set bit of op_done SHALL push its group ID.
REQ-018 Queue push, simultaneous: if op_done=2'b11, group 0 SHALL be pushed ahead of group 1.
REQ-019 Queue full: a push with no free entry SHALL be dropped and set err_sticky[0].
REQ-020 Queue full, partial room: with exactly one free entry and op_done=2'b11, group 0 SHALL be kept and group 1 dropped.
REQ-021 Queue full, same-cycle pop: a pop in the same cycle SHALL free its entry for that cycle's pushes.
REQ-022 FSM states SHALL be IDLE, WAIT, and FIRE.
REQ-023 From IDLE, with the queue non-empty and registered count 0, the FSM SHALL go to FIRE.
REQ-024 From IDLE, with the queue non-empty and registered count nonzero, the FSM SHALL go to WAIT.
REQ-025 From WAIT, the FSM SHALL go to FIRE when the registered count is 0.
REQ-026 From FIRE, the FSM SHALL pop the queue head and go to IDLE.
REQ-027 done_intr_pd SHALL be registered and equal onehot(queue head) only while in FIRE, otherwise 2'b00.
REQ-028 done_intr_pd SHALL never equal 2'b11.
REQ-029 Latency: op_done in cycle N with count 0 and the queue empty SHALL give done_intr_pd high in cycle N+2.
REQ-030 Pulse spacing: consecutive pulses SHALL be at least 2 cycles apart, and SHALL leave in queue order.
REQ-031 Drain rule: writes accepted after an op_done also delay that op's interrupt; this conservative ordering is intended.
REQ-032 err_clr SHALL clear err_sticky next cycle; a set event in the same cycle SHALL win over err_clr.

Reset
REQ-033 On nvdla_core_rstn low, asynchronously: FSM SHALL go to IDLE, queue SHALL empty, and the counter SHALL clear.
REQ-034 On nvdla_core_rstn low, asynchronously: done_intr_pd, outstanding_cnt, pend_cnt and err_sticky SHALL be 0.
REQ-035 Reset asserted mid-WAIT or mid-FIRE SHALL discard pending dones with no pulse emitted.
REQ-036 After reset deasserts, the first rising edge SHALL operate normally.

Configuration
REQ-037 Macro GLB_INTR_WR_DRAIN_EN defined: drain behaviour SHALL be as in REQ-013..REQ-015 and REQ-022..REQ-026.
REQ-038 Macro GLB_INTR_WR_DRAIN_EN undefined: counter and WAIT SHALL be removed; IDLE with the queue non-empty SHALL go directly to FIRE.
REQ-039 Macro GLB_INTR_WR_DRAIN_EN undefined: wr_req_accept and wr_rsp_done SHALL be ignored, outstanding_cnt tied 0, and err_sticky[1] tied 0.

Verification
REQ-040 Scenario: count 0, op_done=2'b01 at cycle 10 -> done_intr_pd=2'b01 in cycle 12 only.
REQ-041 Scenario: 3 wr_req_accept, then op_done=2'b10, responses at cycles 20/25/30 -> count 3->0, done_intr_pd=2'b10 at cycle 32 (WAIT until then).
REQ-042 Scenario: op_done=2'b11 with queue empty, count 0 -> pulses 2'b01 then 2'b10 two cycles apart; pend_cnt goes 2,1,0.
REQ-043 Scenario: count held at 5, 5 single op_done pushes -> 4 queued, err_sticky=2'b01; err_clr -> 2'b00.
REQ-044 Scenario: wr_rsp_done at count 0 -> count stays 0, err_sticky[1]=1; simultaneous req+rsp at count 2 -> stays 2.
REQ-045 Scenario: reset in WAIT with 2 queued -> outputs 0, no pulse after release; macro off -> REQ-041 stimulus pulses at cycle N+2.
